// File: rtl/eth_pcs_scrambler_gen.sv
// eth_pcs_scrambler_gen: 10GBASE-R self-synchronous scrambler/descrambler,
// G(x) = 1 + x^39 + x^58, W_DATA bits unrolled per enabled cycle.
module eth_pcs_scrambler_gen #(
   parameter int W_DATA   = 32,
   parameter int SCR_MODE = 0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_clk_en,
   input  logic              i_valid,
   input  logic [W_DATA-1:0] i_data,
   input  logic              i_seed_load,
   input  logic [57:0]       i_seed,
   input  logic              i_tp_en,
   output logic              o_valid,
   output logic [W_DATA-1:0] o_data,
   output logic              o_locked
);

   localparam logic [5:0] LOCK_FULL = 6'd58;
   localparam logic [6:0] W_INC     = 7'(W_DATA);
   localparam logic       IS_TX     = (SCR_MODE == 0);
   localparam logic       IS_RX     = (SCR_MODE == 1);

   if (W_DATA != 16 && W_DATA != 32 && W_DATA != 64) begin : g_bad_width
      $error("eth_pcs_scrambler_gen: W_DATA must be 16, 32 or 64");
   end

   logic [57:0]       state_q, state_d;
   logic [W_DATA-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic [5:0]        lock_cnt_q, lock_cnt_d;
   logic [W_DATA-1:0] scr_word;
   logic [57:0]       next_state;
   logic [6:0]        lock_sum;
   logic              zero_data;

   assign zero_data = IS_TX & i_tp_en;

   // Bit 0 goes first; descrambler feeds back the received bit.
   always_comb begin
      logic [57:0] s;
      logic        x;
      logic        y;
      s        = state_q;
      x        = 1'b0;
      y        = 1'b0;
      scr_word = '0;
      for (int n = 0; n < W_DATA; n++) begin
         x           = i_data[n] & ~zero_data;
         y           = x ^ s[38] ^ s[57];
         scr_word[n] = y;
         s           = {s[56:0], IS_RX ? x : y};
      end
      next_state = s;
   end

   assign lock_sum = {1'b0, lock_cnt_q} + W_INC;

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      valid_d    = valid_q;
      lock_cnt_d = lock_cnt_q;
      if (i_clk_en) begin
         if (i_seed_load) begin
            state_d    = i_seed;
            lock_cnt_d = '0;
            valid_d    = 1'b0;
         end else if (i_valid) begin
            state_d    = next_state;
            data_d     = scr_word;
            valid_d    = 1'b1;
            lock_cnt_d = (lock_sum >= 7'd58) ? LOCK_FULL
                                             : lock_sum[5:0];
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= '1;
         data_q     <= '0;
         valid_q    <= 1'b0;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   assign o_valid  = valid_q;
   assign o_data   = data_q;
   assign o_locked = IS_TX | (lock_cnt_q == LOCK_FULL);

endmodule

// File: tb/tb_eth_pcs_scrambler_gen.sv
// Bench: W32 scrambler looped into W32 descrambler, plus W16/W64
// descramblers fed from a line-history reference model.
module tb_eth_pcs_scrambler_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;

   logic        a_v = 0, a_sl = 0, a_tp = 0;
   logic [31:0] a_d = '0;
   logic [57:0] a_seed = '0;
   logic        a_ov, a_lk;
   logic [31:0] a_od;

   logic        b_sl = 0, b_tp = 0;
   logic [57:0] b_seed = '0;
   logic        b_ov, b_lk;
   logic [31:0] b_od;

   logic        c_v = 0, c_sl = 0, c_tp = 0;
   logic [15:0] c_d = '0, c_pt = '0;
   logic [57:0] c_seed = '0;
   logic        c_ov, c_lk;
   logic [15:0] c_od;

   logic        d_v = 0, d_sl = 0, d_tp = 0;
   logic [63:0] d_d = '0, d_pt = '0;
   logic [57:0] d_seed = '0;
   logic        d_ov, d_lk;
   logic [63:0] d_od;

   always #5 clk = ~clk;

   eth_pcs_scrambler_gen #(.W_DATA(32), .SCR_MODE(0)) u_a (
      .i_clk(clk), .i_reset(rst_n), .i_clk_en(en), .i_valid(a_v),
      .i_data(a_d), .i_seed_load(a_sl), .i_seed(a_seed), .i_tp_en(a_tp),
      .o_valid(a_ov), .o_data(a_od), .o_locked(a_lk));

   eth_pcs_scrambler_gen #(.W_DATA(32), .SCR_MODE(1)) u_b (
      .i_clk(clk), .i_reset(rst_n), .i_clk_en(en), .i_valid(a_ov),
      .i_data(a_od), .i_seed_load(b_sl), .i_seed(b_seed), .i_tp_en(b_tp),
      .o_valid(b_ov), .o_data(b_od), .o_locked(b_lk));

   eth_pcs_scrambler_gen #(.W_DATA(16), .SCR_MODE(1)) u_c (
      .i_clk(clk), .i_reset(rst_n), .i_clk_en(en), .i_valid(c_v),
      .i_data(c_d), .i_seed_load(c_sl), .i_seed(c_seed), .i_tp_en(c_tp),
      .o_valid(c_ov), .o_data(c_od), .o_locked(c_lk));

   eth_pcs_scrambler_gen #(.W_DATA(64), .SCR_MODE(1)) u_d (
      .i_clk(clk), .i_reset(rst_n), .i_clk_en(en), .i_valid(d_v),
      .i_data(d_d), .i_seed_load(d_sl), .i_seed(d_seed), .i_tp_en(d_tp),
      .o_valid(d_ov), .o_data(d_od), .o_locked(d_lk));

   int          n_cmp = 0;
   int          n_bad = 0;
   bit          lb_on = 0;
   // Line-bit histories, oldest first; last entry is the newest line bit.
   bit          qa[$], qb[$], qc[$], qd[$], qtc[$], qtd[$];
   logic [31:0] pq[$];
   logic [63:0] e_od[4];
   bit          e_ov[4];
   int          e_wd[4];

   function automatic int wid(input int id);
      case (id)
         2:       return 16;
         3:       return 64;
         default: return 32;
      endcase
   endfunction

   function automatic logic [57:0] rnd58();
      return 58'({$urandom(), $urandom()});
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic mseed(ref bit q[$], input logic [57:0] s);
      q.delete();
      for (int k = 57; k >= 0; k--) q.push_back(s[k]);
   endtask

   // Output bit = data ^ line bit 39 ago ^ line bit 58 ago.
   task automatic mstep(ref bit q[$], input logic [63:0] x, input int w,
                        input bit desc, output logic [63:0] y);
      int L;
      bit yb;
      y = '0;
      for (int n = 0; n < w; n++) begin
         L    = q.size();
         yb   = x[n] ^ q[L-39] ^ q[L-58];
         y[n] = yb;
         q.push_back(desc ? x[n] : yb);
         if (q.size() > 58) void'(q.pop_front());
      end
   endtask

   task automatic upd(ref bit q[$], input int id, input bit sl,
                      input logic [57:0] sd, input bit v,
                      input logic [63:0] x, input bit tp);
      logic [63:0] y;
      if (sl) begin
         mseed(q, sd);
         e_wd[id] = 0;
         e_ov[id] = 1'b0;
      end else if (v) begin
         mstep(q, (tp && id == 0) ? 64'd0 : x, wid(id), id != 0, y);
         e_od[id] = y;
         e_ov[id] = 1'b1;
         if (e_wd[id] < 100) e_wd[id]++;
      end else begin
         e_ov[id] = 1'b0;
      end
   endtask

   task automatic rst_models();
      mseed(qa, '1);
      mseed(qb, '1);
      mseed(qc, '1);
      mseed(qd, '1);
      mseed(qtc, '1);
      mseed(qtd, '1);
      for (int id = 0; id < 4; id++) begin
         e_od[id] = '0;
         e_ov[id] = 1'b0;
         e_wd[id] = 0;
      end
      pq.delete();
   endtask

   task automatic chk_all(input string ph);
      logic [63:0] od[4];
      bit          ov[4];
      bit          lk[4];
      bit          el;
      od[0] = 64'(a_od); od[1] = 64'(b_od);
      od[2] = 64'(c_od); od[3] = d_od;
      ov[0] = a_ov; ov[1] = b_ov; ov[2] = c_ov; ov[3] = d_ov;
      lk[0] = a_lk; lk[1] = b_lk; lk[2] = c_lk; lk[3] = d_lk;
      for (int id = 0; id < 4; id++) begin
         el = (id == 0) ? 1'b1 : (e_wd[id] * wid(id) >= 58);
         chk($sformatf("%s.u%0d.valid", ph, id), 64'(ov[id]),
             64'(e_ov[id]));
         chk($sformatf("%s.u%0d.data", ph, id), od[id], e_od[id]);
         chk($sformatf("%s.u%0d.lock", ph, id), 64'(lk[id]), 64'(el));
      end
   endtask

   // Predict one clock edge from the current inputs, then compare.
   task automatic cyc(input string ph);
      logic [63:0] a_o;
      bit          a_pv, ck_b, ck_c, ck_d;
      logic [31:0] b_pt;
      a_o  = e_od[0];
      a_pv = e_ov[0];
      ck_b = 0; ck_c = 0; ck_d = 0;
      b_pt = '0;
      if (en) begin
         if (a_pv && pq.size() > 0) b_pt = pq.pop_front();
         ck_b = lb_on && a_pv && !b_sl && (e_wd[1] * 32 >= 58);
         ck_c = c_v && !c_sl && (e_wd[2] * 16 >= 58);
         ck_d = d_v && !d_sl && (e_wd[3] * 64 >= 58);
         upd(qb, 1, b_sl, b_seed, a_pv, a_o, b_tp);
         if (a_v && !a_sl) pq.push_back(a_tp ? 32'd0 : a_d);
         upd(qa, 0, a_sl, a_seed, a_v, 64'(a_d), a_tp);
         upd(qc, 2, c_sl, c_seed, c_v, 64'(c_d), c_tp);
         upd(qd, 3, d_sl, d_seed, d_v, d_d, d_tp);
      end
      @(posedge clk);
      #1;
      chk_all(ph);
      if (ck_b) chk({ph, ".plain32"}, 64'(b_od), 64'(b_pt));
      if (ck_c) chk({ph, ".plain16"}, 64'(c_od), 64'(c_pt));
      if (ck_d) chk({ph, ".plain64"}, d_od, d_pt);
   endtask

   initial begin
      logic [63:0] y;
      logic [57:0] t;

      rst_models();
      #12;
      chk_all("reset");
      chk("reset.a_lock", 64'(a_lk), 64'd1);
      chk("reset.b_lock", 64'(b_lk), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      a_v = 1; a_d = '0;
      cyc("zero");
      chk("zero.w0", 64'(a_od), 64'h0);
      cyc("zero");
      chk("zero.w1", 64'(a_od), 64'h03FF_FF80);

      // Everything seeded in one cycle, all seeds different.
      a_sl = 1; a_d = $urandom(); a_seed = rnd58();
      b_sl = 1; b_seed = rnd58();
      if (b_seed == a_seed) b_seed = ~a_seed;
      c_sl = 1; c_seed = rnd58(); t = ~c_seed; mseed(qtc, t);
      d_sl = 1; d_seed = rnd58(); t = ~d_seed; mseed(qtd, t);
      cyc("lbseed");
      a_sl = 0; b_sl = 0; c_sl = 0; d_sl = 0;
      lb_on = 1;
      for (int i = 0; i < 1000; i++) begin
         a_d  = $urandom();
         b_tp = 1'($urandom());
         c_tp = 1'($urandom());
         d_tp = 1'($urandom());
         c_pt = 16'($urandom());
         mstep(qtc, 64'(c_pt), 16, 0, y);
         c_d  = y[15:0];
         c_v  = 1;
         d_pt = {$urandom(), $urandom()};
         mstep(qtd, d_pt, 64, 0, y);
         d_d  = y;
         d_v  = 1;
         cyc("lb");
         if (i < 6) begin
            chk($sformatf("lb.lock32.%0d", i), 64'(b_lk), 64'(i >= 2));
            chk($sformatf("lb.lock16.%0d", i), 64'(c_lk), 64'(i >= 3));
            chk($sformatf("lb.lock64.%0d", i), 64'(d_lk), 64'd1);
         end
      end
      lb_on = 0;
      c_v = 0; d_v = 0;

      a_sl = 1; a_v = 1; a_d = $urandom(); a_seed = '1;
      b_sl = 1; b_seed = '1;
      cyc("seedld");
      chk("seedld.a_valid", 64'(a_ov), 64'd0);
      chk("seedld.b_lock", 64'(b_lk), 64'd0);
      a_sl = 0; b_sl = 0; a_d = '0;
      cyc("seedld");
      chk("seedld.zero", 64'(a_od), 64'h0);

      for (int k = 0; k < 12; k++) begin
         en  = (k % 4 == 0) || (k % 4 == 3);
         a_d = $urandom();
         cyc("ce");
      end
      en = 1;

      a_tp = 1;
      for (int k = 0; k < 8; k++) begin
         a_d = $urandom();
         cyc("tp");
      end
      a_tp = 0;
      a_v = 0;
      cyc("idle");

      a_v = 1;
      for (int k = 0; k < 3; k++) begin
         a_d = $urandom();
         cyc("prerst");
      end
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst.a_valid", 64'(a_ov), 64'd0);
      chk("arst.a_data", 64'(a_od), 64'd0);
      chk("arst.b_valid", 64'(b_ov), 64'd0);
      chk("arst.b_data", 64'(b_od), 64'd0);
      chk("arst.b_lock", 64'(b_lk), 64'd0);
      chk("arst.c_lock", 64'(c_lk), 64'd0);
      chk("arst.d_lock", 64'(d_lk), 64'd0);
      rst_models();
      chk_all("arst");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      a_d = '0;
      cyc("restart");
      chk("restart.w0", 64'(a_od), 64'h0);
      cyc("restart");
      chk("restart.w1", 64'(a_od), 64'h03FF_FF80);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
